readmemh_stream_parser: RTL and testbench



---
 rtl/readmemh_pkg.sv | 19 +
 rtl/readmemh_stream_parser_char_class.sv | 24 ++
 rtl/readmemh_stream_parser.sv | 135 +++++++++++++
 tb/tb_readmemh_stream_parser.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/readmemh_pkg.sv
// readmemh_pkg: parser states, error codes, character classes and ASCII constants
package readmemh_pkg;
    typedef enum logic [2:0] {S_WS, S_DATA, S_ADDR, S_SLASH, S_LCOMMENT, S_ERR, S_DONE} state_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_BAD_CHAR, ERR_OVERFLOW, ERR_EMPTY_ADDR} err_t;
    typedef enum logic [2:0] {C_HEX, C_WS, C_UNDERSCORE, C_AT, C_SLASH, C_OTHER} char_class_t;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_LF    = 8'h0a;
    localparam logic [7:0] ASCII_CR    = 8'h0d;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_SLASH = 8'h2f;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_AT    = 8'h40;
    localparam logic [7:0] ASCII_UP_A  = 8'h41;
    localparam logic [7:0] ASCII_UP_F  = 8'h46;
    localparam logic [7:0] ASCII_US    = 8'h5f;
    localparam logic [7:0] ASCII_LO_A  = 8'h61;
    localparam logic [7:0] ASCII_LO_F  = 8'h66;
endpackage

// File: rtl/readmemh_stream_parser_char_class.sv
// readmemh_char_class: classifies one ASCII byte and decodes its hex digit value
module readmemh_char_class
    import readmemh_pkg::*;
(
    input  logic [7:0]  i_byte,
    output char_class_t o_class,
    output logic [3:0]  o_digit
);
    logic w_dec;
    logic w_alpha;
    logic w_ws;
    assign w_dec   = i_byte >= ASCII_0 && i_byte <= ASCII_9;
    assign w_alpha = (i_byte >= ASCII_LO_A && i_byte <= ASCII_LO_F) ||
                     (i_byte >= ASCII_UP_A && i_byte <= ASCII_UP_F);
    assign w_ws    = i_byte == ASCII_SPACE || i_byte == ASCII_TAB ||
                     i_byte == ASCII_CR || i_byte == ASCII_LF;
    // letters a-f/A-F share low nibbles 1..6, so +9 yields 10..15
    assign o_digit = w_dec ? i_byte[3:0] : i_byte[3:0] + 4'd9;
    assign o_class = (w_dec || w_alpha)      ? C_HEX :
                     w_ws                    ? C_WS :
                     (i_byte == ASCII_US)    ? C_UNDERSCORE :
                     (i_byte == ASCII_AT)    ? C_AT :
                     (i_byte == ASCII_SLASH) ? C_SLASH : C_OTHER;
endmodule

// File: rtl/readmemh_stream_parser.sv
// readmemh_stream_parser: parses a writememh-style hex text stream into memory write commands
module readmemh_stream_parser
    import readmemh_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    input  logic [7:0]            i_byte,
    input  logic                  i_last,
    output logic                  o_wr_valid,
    input  logic                  i_wr_ready,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_done,
    output logic                  o_error,
    output logic [1:0]            o_error_code
);
    localparam int ND    = (DATA_WIDTH + 3) / 4;
    localparam int NA    = (ADDR_WIDTH + 3) / 4;
    localparam int MAXD  = ND > NA ? ND : NA;
    localparam int ACC_W = 4 * MAXD;
    localparam int CNT_W = $clog2(MAXD + 1);

    state_t                r_state, w_state_nxt;
    err_t                  r_err_code, w_err;
    logic [ACC_W-1:0]      r_acc, w_acc_nxt, w_shifted;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_wr_valid, w_accept, w_emit, w_load;
    char_class_t           w_class;
    logic [3:0]            w_digit;

    readmemh_char_class u_class (.i_byte(i_byte), .o_class(w_class), .o_digit(w_digit));

    assign o_byte_ready = r_state != S_ERR && r_state != S_DONE && (!r_wr_valid || i_wr_ready);
    assign w_accept     = i_byte_valid && o_byte_ready;
    assign w_shifted    = {r_acc[ACC_W-5:0], w_digit};
    assign o_wr_valid   = r_wr_valid;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_done       = r_state == S_DONE && !r_wr_valid;
    assign o_error      = r_state == S_ERR;
    assign o_error_code = r_err_code;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_err       = ERR_NONE;
        w_emit      = 1'b0;
        w_load      = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_WS: case (w_class)
                    C_HEX: begin
                        w_state_nxt = S_DATA;
                        w_acc_nxt   = ACC_W'(w_digit);
                        w_cnt_nxt   = CNT_W'(1);
                    end
                    C_AT: begin
                        w_state_nxt = S_ADDR;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                    C_SLASH: w_state_nxt = S_SLASH;
                    C_WS: ;
                    default: w_err = ERR_BAD_CHAR;
                endcase
                S_DATA, S_ADDR: case (w_class)
                    C_HEX: begin
                        if (r_cnt == CNT_W'(r_state == S_DATA ? ND : NA)) w_err = ERR_OVERFLOW;
                        else begin
                            w_acc_nxt = w_shifted;
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                    C_UNDERSCORE: ;
                    C_WS, C_SLASH: begin
                        if (r_state == S_ADDR && r_cnt == '0) w_err = ERR_EMPTY_ADDR;
                        else begin
                            w_emit      = r_state == S_DATA;
                            w_load      = r_state == S_ADDR;
                            w_state_nxt = w_class == C_WS ? S_WS : S_SLASH;
                        end
                    end
                    default: w_err = ERR_BAD_CHAR;
                endcase
                S_SLASH: if (w_class == C_SLASH) w_state_nxt = S_LCOMMENT; else w_err = ERR_BAD_CHAR;
                S_LCOMMENT: if (i_byte == ASCII_LF) w_state_nxt = S_WS;
                default: ;
            endcase
            // end of stream behaves like a trailing whitespace byte, then finishes
            if (i_last && w_err == ERR_NONE) begin
                if (w_state_nxt == S_SLASH) w_err = ERR_BAD_CHAR;
                else if (w_state_nxt == S_ADDR && w_cnt_nxt == '0) w_err = ERR_EMPTY_ADDR;
                else begin
                    w_emit      = w_emit || w_state_nxt == S_DATA;
                    w_load      = w_load || w_state_nxt == S_ADDR;
                    w_state_nxt = S_DONE;
                end
            end
            if (w_err != ERR_NONE) w_state_nxt = S_ERR;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_WS;
            r_err_code <= ERR_NONE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_err != ERR_NONE) r_err_code <= w_err;
            if (w_emit) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= DATA_WIDTH'(w_acc_nxt);
            end else if (i_wr_ready) r_wr_valid <= 1'b0;
            if (w_load) r_addr <= ADDR_WIDTH'(w_acc_nxt);
            else if (w_emit) r_addr <= r_addr + ADDR_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_readmemh_stream_parser.sv
// tb_readmemh_stream_parser: directed and random hex-image streams against a tokenizer model
module tb_readmemh_stream_parser;
    localparam int ND = 8;
    localparam int NA = 4;

    logic        clk = 1'b0;
    logic        rst, byte_valid, byte_ready, last, wr_valid, wr_ready, done, error;
    logic [7:0]  byte_in;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  error_code;
    int          mode, stalls;
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  s[$];
    bit          s_last;
    logic [15:0] exp_a[$], got_a[$];
    logic [31:0] exp_d[$], got_d[$];
    int          exp_err;
    bit          exp_done;

    readmemh_stream_parser #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_byte_valid(byte_valid), .o_byte_ready(byte_ready),
        .i_byte(byte_in), .i_last(last), .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_done(done), .o_error(error),
        .o_error_code(error_code)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sink: 0 always ready, 1 random backpressure, 2 held off
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            wr_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
        end
    end

    always @(negedge clk) if (rst && wr_valid && wr_ready) begin
        got_a.push_back(wr_addr);
        got_d.push_back(wr_data);
    end

    function automatic bit is_hex(logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
    endfunction
    function automatic int hexval(logic [7:0] c);
        if (c <= "9") return int'(c) - 48;
        if (c >= "a") return int'(c) - 87;
        return int'(c) - 55;
    endfunction
    function automatic bit is_ws(logic [7:0] c);
        return c == 8'h20 || c == 8'h09 || c == 8'h0a || c == 8'h0d;
    endfunction

    // token-level reader: walks whole tokens with lookahead to their delimiter
    task automatic model();
        int i, j, n, dig, lim;
        bit stop, isa;
        longint val;
        logic [15:0] addr;
        i = 0; n = s.size(); stop = 0; addr = 0;
        exp_a.delete(); exp_d.delete(); exp_err = 0;
        while (i < n && exp_err == 0 && !stop) begin
            if (is_ws(s[i])) i++;
            else if (s[i] == "/") begin
                if (i + 1 >= n) begin if (s_last) exp_err = 1; stop = 1; end
                else if (s[i+1] != "/") exp_err = 1;
                else begin
                    i += 2;
                    while (i < n && s[i] != 8'h0a) i++;
                    i++;
                end
            end else if (s[i] == "@" || is_hex(s[i])) begin
                isa = s[i] == "@"; lim = isa ? NA : ND; dig = 0; val = 0;
                j = isa ? i + 1 : i;
                while (j < n && (is_hex(s[j]) || s[j] == "_") && exp_err == 0) begin
                    if (is_hex(s[j])) begin
                        dig++;
                        if (dig > lim) exp_err = 2; else val = val * 16 + hexval(s[j]);
                    end
                    j++;
                end
                if (exp_err == 0) begin
                    if (j < n && !is_ws(s[j]) && s[j] != "/") exp_err = 1;
                    else if (j >= n && !s_last) stop = 1;
                    else if (isa && dig == 0) exp_err = 3;
                    else if (isa) addr = val[15:0];
                    else begin exp_a.push_back(addr); exp_d.push_back(val[31:0]); addr++; end
                    i = j;
                end
            end else exp_err = 1;
        end
        exp_done = s_last && exp_err == 0 && !stop;
    endtask

    task automatic do_reset();
        rst = 1'b0; byte_valid = 1'b0; last = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        got_a.delete(); got_d.delete();
    endtask

    task automatic send_byte(logic [7:0] b, bit l);
        int k;
        bit ok, dead;
        k = 0; ok = 0; dead = 0;
        byte_valid = 1'b1; byte_in = b; last = l;
        while (!ok && !dead && k < 200) begin
            @(negedge clk);
            if (byte_ready) ok = 1;
            else if (error || done) dead = 1;
            else begin @(posedge clk); #1; k++; end
        end
        if (!ok && !dead) stalls++;
        @(posedge clk); #1;
        byte_valid = 1'b0; last = 1'b0;
    endtask

    task automatic send_stream();
        for (int i = 0; i < s.size(); i++) begin
            if (error || done) break;
            send_byte(s[i], s_last && i == s.size() - 1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (k < 400 && (wr_valid || (exp_done && !done))) begin @(posedge clk); #1; k++; end
        if (k == 400) stalls++;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic compare();
        check("n_writes", got_a.size(), exp_a.size());
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            check("wr_addr", got_a[i], exp_a[i]);
            check("wr_data", got_d[i], exp_d[i]);
        end
        check("error", error, exp_err != 0);
        check("error_code", error_code, exp_err);
        check("done", done, exp_done);
        check("bounded_wait", stalls, 0);
        if (exp_err != 0 || exp_done) check("ready_low", byte_ready, 0);
    endtask

    task automatic load(string t, bit l);
        s.delete();
        for (int i = 0; i < t.len(); i++) s.push_back(t[i]);
        s_last = l;
    endtask

    task automatic run_loaded(int m);
        mode = m;
        do_reset();
        stalls = 0;
        model();
        send_stream();
        drain();
        compare();
    endtask

    task automatic gen_random();
        string hexs = "0123456789abcdefABCDEF";
        logic [7:0] seps[4] = '{8'h20, 8'h09, 8'h0d, 8'h0a};
        int r, nd;
        s.delete(); s_last = 1;
        repeat ($urandom_range(3, 12)) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                s.push_back(8'h40);
                repeat ($urandom_range(1, NA)) s.push_back(hexs[$urandom_range(0, 21)]);
            end else if (r == 1) begin
                s.push_back(8'h2f); s.push_back(8'h2f);
                repeat ($urandom_range(0, 5)) s.push_back(8'($urandom_range(32, 126)));
                s.push_back(8'h0a);
            end else begin
                nd = ($urandom_range(0, 14) == 0) ? 9 : $urandom_range(1, ND);
                for (int k = 0; k < nd; k++) begin
                    s.push_back(hexs[$urandom_range(0, 21)]);
                    if ($urandom_range(0, 5) == 0) s.push_back(8'h5f);
                end
            end
            s.push_back(seps[$urandom_range(0, 3)]);
        end
        if ($urandom_range(0, 1) == 1) void'(s.pop_back());
        if ($urandom_range(0, 7) == 0) s[$urandom_range(0, s.size() - 1)] = 8'($urandom_range(32, 126));
    endtask

    initial begin
        rst = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; last = 1'b0; mode = 0; stalls = 0;
        do_reset();
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_error_code", error_code, 0);
        check("rst_byte_ready", byte_ready, 1);

        load("12 ab\nFF", 1); run_loaded(0);
        check("basic_last_data", got_d.size() == 3 ? got_d[2] : 32'hdead, 32'hff);
        load("@fffe 1 2 3", 1); run_loaded(1);
        check("wrap_addr", got_a.size() == 3 ? got_a[2] : 16'hdead, 16'h0000);
        load("dead_beef // c 9\n5", 1); run_loaded(1);
        load("123456789 ", 0); run_loaded(0);
        load("@ 5", 0); run_loaded(0);
        load("1g", 0); run_loaded(0);
        load("/x", 1); run_loaded(0);
        load("@12/", 1); run_loaded(0);

        // backpressure: first command held while the sink refuses it
        mode = 2; do_reset(); stalls = 0;
        repeat (2) begin @(posedge clk); #1; end
        send_byte("1", 0); send_byte(" ", 0);
        byte_valid = 1'b1; byte_in = "2";
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", wr_valid, 1);
            check("bp_hold_data", wr_data, 1);
            check("bp_ready_low", byte_ready, 0);
        end
        check("bp_hold_addr", wr_addr, 0);
        @(posedge clk); #1; byte_valid = 1'b0;
        mode = 0;
        send_byte("2", 0); send_byte(" ", 0); send_byte("3", 0); send_byte(" ", 0);
        load("1 2 3 ", 0); model(); drain(); compare();

        // reset with a pending write, then reset mid-token
        mode = 2; do_reset(); stalls = 0;
        repeat (2) begin @(posedge clk); #1; end
        send_byte("9", 0); send_byte(" ", 0);
        check("pend_valid", wr_valid, 1);
        do_reset();
        check("pend_cleared", wr_valid, 0);
        check("pend_data_zero", wr_data, 0);
        mode = 0;
        send_byte("4", 0); send_byte("5", 0);
        do_reset();
        check("mid_wr_addr", wr_addr, 0);
        check("mid_done", done, 0);
        check("mid_error", error, 0);
        load("7", 1); model(); send_stream(); drain(); compare();
        check("after_rst_addr", got_a.size() == 1 ? got_a[0] : 16'hdead, 16'h0000);

        for (int t = 0; t < 30; t++) begin
            gen_random();
            run_loaded($urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
